// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - fetch/LSU arbiter for the unified single-ported memory
`timescale 1ns/1ps
module mem_arbiter #(
  parameter int ADDWIDTH      = 12,
  parameter int MAX_LS_STREAK = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  if_req,
  input  logic [ADDWIDTH+1:0]   if_addr,
  output logic                  if_gnt,
  output logic                  if_rvalid,
  output logic [31:0]           if_rdata,
  input  logic                  ls_req,
  input  logic                  ls_we,
  input  logic [ADDWIDTH+1:0]   ls_addr,
  input  logic [1:0]            ls_size,
  input  logic                  ls_unsigned,
  input  logic [31:0]           ls_wdata,
  output logic                  ls_gnt,
  output logic                  ls_rvalid,
  output logic [31:0]           ls_rdata,
  output logic                  ls_err,
  output logic [ADDWIDTH-1:0]   mem_addr,
  output logic                  mem_ld,
  output logic                  mem_str,
  output logic [3:0]            mem_be,
  output logic [31:0]           mem_wdata,
  input  logic [31:0]           mem_rdata
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ISSUE = 2'd1;
  localparam logic [1:0] ST_RESP  = 2'd2;
  localparam logic [3:0] STREAK_MAX = 4'(MAX_LS_STREAK);

  logic [1:0]          state_q, state_d;
  logic                sel_ls_q, sel_ls_d;
  logic                we_q, we_d;
  logic [ADDWIDTH+1:0] addr_q, addr_d;
  logic [1:0]          size_q, size_d;
  logic                uns_q, uns_d;
  logic [31:0]         wdata_q, wdata_d;
  logic                err_q, err_d;
  logic [3:0]          streak_q, streak_d;

  logic                pick_ls, pick_if, req_err;
  logic                in_issue, in_resp;
  logic [3:0]          st_be;
  logic [31:0]         st_wdata, ld_data;
  logic [7:0]          ld_byte;
  logic [15:0]         ld_half;

  // LSU wins unless fetch has waited through a full LSU streak
  assign pick_ls = ls_req && !(if_req && (streak_q == STREAK_MAX));
  assign pick_if = if_req && !pick_ls;

  // Flag illegal sizes and accesses not aligned to their own size
  always_comb begin
    req_err = 1'b0;
    case (ls_size)
      2'b01:   req_err = ls_addr[0];
      2'b10:   req_err = |ls_addr[1:0];
      2'b11:   req_err = 1'b1;
      default: req_err = 1'b0;
    endcase
  end

  // Next state: arbitrate and capture in IDLE/RESP, ISSUE always lasts one cycle
  always_comb begin
    state_d  = state_q;
    sel_ls_d = sel_ls_q;
    we_d     = we_q;
    addr_d   = addr_q;
    size_d   = size_q;
    uns_d    = uns_q;
    wdata_d  = wdata_q;
    err_d    = err_q;
    streak_d = streak_q;
    if (state_q == ST_ISSUE) begin
      state_d = ST_RESP;
    end else begin
      state_d = ST_IDLE;
      if (pick_ls) begin
        state_d  = ST_ISSUE;
        sel_ls_d = 1'b1;
        we_d     = ls_we;
        addr_d   = ls_addr;
        size_d   = ls_size;
        uns_d    = ls_unsigned;
        wdata_d  = ls_wdata;
        err_d    = req_err;
      end else if (pick_if) begin
        state_d  = ST_ISSUE;
        sel_ls_d = 1'b0;
        we_d     = 1'b0;
        addr_d   = if_addr;
        size_d   = 2'b10;
        uns_d    = 1'b0;
        wdata_d  = '0;
        err_d    = 1'b0;
      end
      if (!if_req || pick_if) begin
        streak_d = '0;
      end else if (pick_ls && (streak_q != STREAK_MAX)) begin
        streak_d = streak_q + 4'd1;
      end
    end
  end

  // State and captured-request registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      sel_ls_q <= 1'b0;
      we_q     <= 1'b0;
      addr_q   <= '0;
      size_q   <= '0;
      uns_q    <= 1'b0;
      wdata_q  <= '0;
      err_q    <= 1'b0;
      streak_q <= '0;
    end else begin
      state_q  <= state_d;
      sel_ls_q <= sel_ls_d;
      we_q     <= we_d;
      addr_q   <= addr_d;
      size_q   <= size_d;
      uns_q    <= uns_d;
      wdata_q  <= wdata_d;
      err_q    <= err_d;
      streak_q <= streak_d;
    end
  end

  assign in_issue = (state_q == ST_ISSUE);
  assign in_resp  = (state_q == ST_RESP);

  // Store lane steering: enables follow the offset, data is replicated per lane
  always_comb begin
    st_be    = 4'b1111;
    st_wdata = wdata_q;
    case (size_q)
      2'b00: begin
        st_be    = 4'b0001 << addr_q[1:0];
        st_wdata = {4{wdata_q[7:0]}};
      end
      2'b01: begin
        st_be    = addr_q[1] ? 4'b1100 : 4'b0011;
        st_wdata = {2{wdata_q[15:0]}};
      end
      default: begin
        st_be    = 4'b1111;
        st_wdata = wdata_q;
      end
    endcase
  end

  // Load extraction from the registered memory output, with sign/zero extension
  always_comb begin
    ld_byte = mem_rdata[{addr_q[1:0], 3'b000} +: 8];
    ld_half = mem_rdata[{addr_q[1], 4'b0000} +: 16];
    case (size_q)
      2'b00:   ld_data = uns_q ? {24'h0, ld_byte} : {{24{ld_byte[7]}}, ld_byte};
      2'b01:   ld_data = uns_q ? {16'h0, ld_half} : {{16{ld_half[15]}}, ld_half};
      default: ld_data = mem_rdata;
    endcase
  end

  assign if_gnt    = in_issue && !sel_ls_q;
  assign ls_gnt    = in_issue && sel_ls_q;
  assign if_rvalid = in_resp && !sel_ls_q;
  assign ls_rvalid = in_resp && sel_ls_q;
  assign ls_err    = ls_rvalid && err_q;
  assign if_rdata  = if_rvalid ? mem_rdata : '0;
  assign ls_rdata  = (ls_rvalid && !we_q && !err_q) ? ld_data : '0;

  assign mem_addr  = in_issue ? addr_q[ADDWIDTH+1:2] : '0;
  assign mem_ld    = in_issue && !we_q && !err_q;
  assign mem_str   = in_issue && we_q && !err_q;
  assign mem_be    = mem_str ? st_be : 4'b0000;
  assign mem_wdata = mem_str ? st_wdata : '0;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - self-checking bench for mem_arbiter
`timescale 1ns/1ps
module tb_mem_arbiter;

  localparam int AW  = 12;
  localparam int MAX = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          if_req = 1'b0;
  logic [AW+1:0] if_addr = '0;
  logic          if_gnt, if_rvalid;
  logic [31:0]   if_rdata;
  logic          ls_req = 1'b0, ls_we = 1'b0, ls_unsigned = 1'b0;
  logic [AW+1:0] ls_addr = '0;
  logic [1:0]    ls_size = '0;
  logic [31:0]   ls_wdata = '0;
  logic          ls_gnt, ls_rvalid, ls_err;
  logic [31:0]   ls_rdata;
  logic [AW-1:0] mem_addr;
  logic          mem_ld, mem_str;
  logic [3:0]    mem_be;
  logic [31:0]   mem_wdata;
  logic [31:0]   mem_rdata = '0;

  mem_arbiter #(.ADDWIDTH(AW), .MAX_LS_STREAK(MAX)) dut (
    .clk(clk), .rst_n(rst_n),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt), .if_rvalid(if_rvalid), .if_rdata(if_rdata),
    .ls_req(ls_req), .ls_we(ls_we), .ls_addr(ls_addr), .ls_size(ls_size), .ls_unsigned(ls_unsigned),
    .ls_wdata(ls_wdata), .ls_gnt(ls_gnt), .ls_rvalid(ls_rvalid), .ls_rdata(ls_rdata), .ls_err(ls_err),
    .mem_addr(mem_addr), .mem_ld(mem_ld), .mem_str(mem_str), .mem_be(mem_be),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [63:0] ctl_vec();
    return 64'({if_gnt, if_rvalid, ls_gnt, ls_rvalid, ls_err, mem_ld, mem_str, mem_be});
  endfunction

  function automatic logic [63:0] dat_vec();
    return 64'(|{if_rdata, ls_rdata, mem_addr, mem_wdata});
  endfunction

  // Reference: access legality from size and byte offset
  function automatic bit bad_access(input logic [AW+1:0] a, input logic [1:0] sz);
    int nb;
    nb = 1 << sz;
    return (sz == 2'd3) || ((int'(a) % nb) != 0);
  endfunction

  // Reference: lane enables and replicated data, byte by byte
  function automatic void store_model(input logic [AW+1:0] a, input logic [1:0] sz,
                                      input logic [31:0] wd, output logic [3:0] be,
                                      output logic [31:0] lanes);
    int nb, off;
    nb = 1 << sz;
    off = int'(a) % 4;
    be = '0;
    lanes = '0;
    for (int b = 0; b < 4; b++) begin
      if (b >= off && b < off + nb) be[b] = 1'b1;
      lanes[8*b +: 8] = wd[8*(b % nb) +: 8];
    end
  endfunction

  // Reference: load value by shift, modulo and two's-complement arithmetic
  function automatic logic [31:0] load_model(input logic [31:0] rd, input logic [AW+1:0] a,
                                             input logic [1:0] sz, input bit uns);
    longint v, span;
    int nb;
    if (sz == 2'd2) return rd;
    nb = 1 << sz;
    span = longint'(1) << (8 * nb);
    v = (longint'(rd) >> (8 * (int'(a) % 4))) % span;
    if (!uns && v >= span / 2) v = v - span;
    return 32'(v);
  endfunction

  typedef struct {
    logic          we;
    logic [AW+1:0] addr;
    logic [1:0]    size;
    logic          uns;
    logic [31:0]   wdata;
    logic [31:0]   rdata;
    logic          ld;
    logic          str;
    logic [3:0]    be;
    logic [31:0]   mwd;
    logic [AW-1:0] maddr;
    logic          err;
    logic [31:0]   res;
  } vec_t;

  vec_t tbl[14];

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    if_req = 1'b0;
    ls_req = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Random-test model state and per-cycle expectations
  int          streak_m;
  bit          prev_issue, issue_now, resp_now, win_ls, win_if;
  bit          t_ls, t_we, t_uns, t_err;
  logic [AW+1:0] t_addr;
  logic [1:0]  t_size;
  logic [31:0] t_wdata, e_wd, e_ifd, e_lsd;
  logic [3:0]  e_be;
  logic [10:0] e_ctl;
  int          gi, last_f;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    tbl[0]  = '{1'b1, 14'h106,  2'd0, 1'b0, 32'hDEADBEEF, 32'h0,        1'b0, 1'b1, 4'b0100, 32'hEFEFEFEF, 12'h041, 1'b0, 32'h0};
    tbl[1]  = '{1'b0, 14'h0FE,  2'd1, 1'b0, 32'h0,        32'h80011234, 1'b1, 1'b0, 4'b0000, 32'h0,        12'h03F, 1'b0, 32'hFFFF8001};
    tbl[2]  = '{1'b0, 14'h0FD,  2'd0, 1'b1, 32'h0,        32'h80011234, 1'b1, 1'b0, 4'b0000, 32'h0,        12'h03F, 1'b0, 32'h00000012};
    tbl[3]  = '{1'b0, 14'h103,  2'd2, 1'b0, 32'h0,        32'hFFFFFFFF, 1'b0, 1'b0, 4'b0000, 32'h0,        12'h040, 1'b1, 32'h0};
    tbl[4]  = '{1'b1, 14'h10A,  2'd1, 1'b0, 32'h1234CAFE, 32'h0,        1'b0, 1'b1, 4'b1100, 32'hCAFECAFE, 12'h042, 1'b0, 32'h0};
    tbl[5]  = '{1'b1, 14'h200,  2'd2, 1'b0, 32'h01234567, 32'h0,        1'b0, 1'b1, 4'b1111, 32'h01234567, 12'h080, 1'b0, 32'h0};
    tbl[6]  = '{1'b0, 14'h003,  2'd0, 1'b0, 32'h0,        32'h9A345678, 1'b1, 1'b0, 4'b0000, 32'h0,        12'h000, 1'b0, 32'hFFFFFF9A};
    tbl[7]  = '{1'b0, 14'h002,  2'd1, 1'b1, 32'h0,        32'h9A345678, 1'b1, 1'b0, 4'b0000, 32'h0,        12'h000, 1'b0, 32'h00009A34};
    tbl[8]  = '{1'b0, 14'h000,  2'd3, 1'b0, 32'h0,        32'h12345678, 1'b0, 1'b0, 4'b0000, 32'h0,        12'h000, 1'b1, 32'h0};
    tbl[9]  = '{1'b1, 14'h101,  2'd1, 1'b0, 32'hAAAA5555, 32'h0,        1'b0, 1'b0, 4'b0000, 32'h0,        12'h040, 1'b1, 32'h0};
    tbl[10] = '{1'b0, 14'h3FFC, 2'd2, 1'b0, 32'h0,        32'hCAFEF00D, 1'b1, 1'b0, 4'b0000, 32'h0,        12'hFFF, 1'b0, 32'hCAFEF00D};
    tbl[11] = '{1'b0, 14'h000,  2'd1, 1'b0, 32'h0,        32'h00007FFF, 1'b1, 1'b0, 4'b0000, 32'h0,        12'h000, 1'b0, 32'h00007FFF};
    tbl[12] = '{1'b1, 14'h0FF,  2'd0, 1'b0, 32'h000000A5, 32'h0,        1'b0, 1'b1, 4'b1000, 32'hA5A5A5A5, 12'h03F, 1'b0, 32'h0};
    tbl[13] = '{1'b0, 14'h001,  2'd0, 1'b0, 32'h0,        32'h9A345678, 1'b1, 1'b0, 4'b0000, 32'h0,        12'h000, 1'b0, 32'h00000056};

    // Reset state
    @(negedge clk);
    @(negedge clk);
    chk("reset_ctl", ctl_vec(), 64'h0);
    chk("reset_data", dat_vec(), 64'h0);
    rst_n = 1'b1;

    // Lone fetch
    @(negedge clk);
    if_req = 1'b1;
    if_addr = 14'h804;
    @(negedge clk);
    chk("fetch_gnt", 64'({if_gnt, ls_gnt, mem_ld, mem_str}), 64'b1010);
    chk("fetch_maddr", 64'(mem_addr), 64'h201);
    if_req = 1'b0;
    mem_rdata = 32'h00A00093;
    @(negedge clk);
    chk("fetch_rvalid", 64'({if_rvalid, ls_rvalid}), 64'b10);
    chk("fetch_rdata", 64'(if_rdata), 64'h00A00093);

    // Table-driven single LSU accesses
    for (int i = 0; i < 14; i++) begin
      @(negedge clk);
      ls_req = 1'b1;
      ls_we = tbl[i].we;
      ls_addr = tbl[i].addr;
      ls_size = tbl[i].size;
      ls_unsigned = tbl[i].uns;
      ls_wdata = tbl[i].wdata;
      @(negedge clk);
      chk($sformatf("v%0d_gnt", i), 64'({if_gnt, ls_gnt}), 64'b01);
      chk($sformatf("v%0d_ldstr", i), 64'({mem_ld, mem_str}), 64'({tbl[i].ld, tbl[i].str}));
      chk($sformatf("v%0d_be", i), 64'(mem_be), 64'(tbl[i].be));
      chk($sformatf("v%0d_wdata", i), 64'(mem_wdata), 64'(tbl[i].mwd));
      chk($sformatf("v%0d_maddr", i), 64'(mem_addr), 64'(tbl[i].maddr));
      ls_req = 1'b0;
      mem_rdata = tbl[i].rdata;
      @(negedge clk);
      chk($sformatf("v%0d_rvalid", i), 64'({if_rvalid, ls_rvalid, ls_err}), 64'({2'b01, tbl[i].err}));
      chk($sformatf("v%0d_rdata", i), 64'(ls_rdata), 64'(tbl[i].res));
    end

    // Contention: both held, expect L,L,L,L,F repeating
    do_reset();
    @(negedge clk);
    if_req = 1'b1;
    if_addr = 14'h100;
    ls_req = 1'b1;
    ls_we = 1'b0;
    ls_addr = 14'h010;
    ls_size = 2'd2;
    ls_unsigned = 1'b0;
    gi = 0;
    last_f = -1;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      chk("cont_onehot", 64'(if_gnt & ls_gnt), 64'h0);
      if (if_gnt || ls_gnt) begin
        chk($sformatf("cont_grant%0d", gi), 64'(if_gnt), 64'((gi % 5) == 4));
        if (if_gnt) begin
          if (last_f >= 0) chk("cont_spacing", 64'(c - last_f), 64'd10);
          last_f = c;
        end
        gi++;
      end
    end
    chk("cont_count", 64'(gi), 64'd20);

    // Reset mid-access
    do_reset();
    @(negedge clk);
    ls_req = 1'b1;
    ls_we = 1'b0;
    ls_addr = 14'h020;
    ls_size = 2'd2;
    @(negedge clk);
    chk("rma_issue", 64'({ls_gnt, mem_ld}), 64'b11);
    rst_n = 1'b0;
    ls_req = 1'b0;
    if_req = 1'b1;
    if_addr = 14'h044;
    #1;
    chk("rma_ctl_now", ctl_vec(), 64'h0);
    chk("rma_data_now", dat_vec(), 64'h0);
    @(negedge clk);
    chk("rma_no_resp", ctl_vec(), 64'h0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rma_if_gnt", 64'({if_gnt, ls_gnt, mem_ld}), 64'b101);
    chk("rma_maddr", 64'(mem_addr), 64'h011);
    if_req = 1'b0;
    mem_rdata = 32'h13572468;
    @(negedge clk);
    chk("rma_if_resp", 64'({if_rvalid, if_rdata}), {31'h0, 1'b1, 32'h13572468});

    // Randomized traffic against the transaction-level model
    do_reset();
    streak_m = 0;
    prev_issue = 1'b0;
    t_ls = 1'b0; t_we = 1'b0; t_uns = 1'b0; t_err = 1'b0;
    t_addr = '0; t_size = '0; t_wdata = '0;
    for (int c = 0; c < 600; c++) begin
      @(posedge clk);
      issue_now = 1'b0;
      resp_now = 1'b0;
      if (prev_issue) begin
        prev_issue = 1'b0;
        resp_now = 1'b1;
      end else begin
        win_ls = ls_req && (!if_req || streak_m < MAX);
        win_if = if_req && !win_ls;
        if (!if_req || win_if) streak_m = 0;
        else if (win_ls && streak_m < MAX) streak_m++;
        if (win_ls) begin
          t_ls = 1'b1; t_we = ls_we; t_addr = ls_addr; t_size = ls_size;
          t_uns = ls_unsigned; t_wdata = ls_wdata; t_err = bad_access(ls_addr, ls_size);
        end else if (win_if) begin
          t_ls = 1'b0; t_we = 1'b0; t_addr = if_addr; t_err = 1'b0;
        end
        issue_now = win_ls || win_if;
        prev_issue = issue_now;
      end
      @(negedge clk);
      e_ctl = '0;
      e_wd = '0;
      e_ifd = '0;
      e_lsd = '0;
      e_be = '0;
      if (issue_now) begin
        if (t_we && !t_err) store_model(t_addr, t_size, t_wdata, e_be, e_wd);
        e_ctl = {!t_ls, 1'b0, t_ls, 1'b0, 1'b0, !t_we && !t_err, t_we && !t_err, e_be};
        chk("rnd_maddr", 64'(mem_addr), 64'(t_addr >> 2));
      end else if (resp_now) begin
        e_ctl = {1'b0, !t_ls, 1'b0, t_ls, t_ls && t_err, 6'b0};
        if (!t_ls) e_ifd = mem_rdata;
        else if (!t_we && !t_err) e_lsd = load_model(mem_rdata, t_addr, t_size, t_uns);
      end
      chk("rnd_ctl", ctl_vec(), 64'(e_ctl));
      chk("rnd_wdata", 64'(mem_wdata), 64'(e_wd));
      chk("rnd_rdata", 64'({if_rdata, ls_rdata}), {e_ifd, e_lsd});
      if (issue_now && t_ls) ls_req = 1'b0;
      if (issue_now && !t_ls) if_req = 1'b0;
      if (!ls_req && ($urandom % 2 == 0)) begin
        ls_req = 1'b1;
        ls_we = 1'($urandom);
        ls_addr = 14'($urandom);
        ls_size = 2'($urandom);
        ls_unsigned = 1'($urandom);
        ls_wdata = $urandom;
      end
      if (!if_req && ($urandom % 2 == 0)) begin
        if_req = 1'b1;
        if_addr = 14'($urandom);
      end
      mem_rdata = $urandom;
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Shares the single-ported unified instruction/data memory between the instruction-fetch unit and the load/store unit of the RV32I core. It arbitrates one access at a time and converts byte addresses to word addresses. For stores it generates byte enables and lane-aligned write data; for loads it returns extracted, sign- or zero-extended data. It sits between the core's fetch/LSU stages and the memory macro, which has a registered read with 1-cycle latency.

## Interface
- `ADDWIDTH`, default 12: memory word-address width; requester byte addresses are ADDWIDTH+2 bits.
- `MAX_LS_STREAK`, default 4: max consecutive LSU grants while fetch is waiting (range 1..15).

- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `if_req` in 1: fetch request; held with `if_addr` stable until `if_gnt`.
- `if_addr` in ADDWIDTH+2: fetch byte address; bits [1:0] ignored.
- `if_gnt` out 1: one-cycle grant pulse.
- `if_rvalid` out 1: one-cycle pulse when `if_rdata` is valid.
- `if_rdata` out 32: instruction word.
- `ls_req` in 1: LSU request; held with all `ls_*` inputs stable until `ls_gnt`.
- `ls_we` in 1: 1 = store, 0 = load.
- `ls_addr` in ADDWIDTH+2: byte address.
- `ls_size` in 2: 00 = byte, 01 = half, 10 = word, 11 = illegal.
- `ls_unsigned` in 1: zero-extend the load (LBU/LHU).
- `ls_wdata` in 32: store data, right-aligned.
- `ls_gnt` out 1: one-cycle grant pulse.
- `ls_rvalid` out 1: one-cycle response pulse; for both loads and stores.
- `ls_rdata` out 32: extended load data; 0 for stores and errors.
- `ls_err` out 1: valid with `ls_rvalid`; flags a misaligned or illegal access.
- `mem_addr` out ADDWIDTH: word address.
- `mem_ld` out 1: read strobe.
- `mem_str` out 1: write strobe.
- `mem_be` out 4: byte enables; 0000 when `mem_str` is 0.
- `mem_wdata` out 32: lane-aligned write data.
- `mem_rdata` in 32: read data, valid the cycle after `mem_ld`.

## Operation
- **FSM states:** IDLE, ISSUE, RESP.
- **Arbitration:** happens in IDLE and RESP. The request is captured into internal registers and the FSM moves to ISSUE.
  - If no request is pending: RESP goes to IDLE, and IDLE stays in IDLE.
- **Priority:** LSU wins by default. Fetch wins when `ls_streak == MAX_LS_STREAK`, or when only `if_req` is asserted.
- **`ls_streak`:**
  - Increments on each LSU grant made while `if_req` = 1, saturating at MAX_LS_STREAK.
  - Clears on any fetch grant.
  - Clears when an arbitration sees `if_req` = 0.
- **ISSUE (exactly one cycle):**
  - Pulse `if_gnt` or `ls_gnt` for the captured requester.
  - Drive `mem_addr` = addr[ADDWIDTH+1:2].
  - Assert `mem_ld` for a fetch or load, or `mem_str` for a store.
  - Then go to RESP.
- **Misalignment check.** An access is an error if any of the following holds:
  - size = 11.
  - half with addr[0] = 1.
  - word with addr[1:0] ≠ 00.
- **Error handling:** for an error, ISSUE still pulses `ls_gnt` but asserts neither `mem_ld` nor `mem_str`. RESP then gives `ls_err` = 1 and `ls_rdata` = 0.
- **Store byte enables and data:**
  - byte: `mem_be` = 0001 << addr[1:0]; wdata = {4{wdata[7:0]}}.
  - half: `mem_be` = addr[1] ? 1100 : 0011; wdata = {2{wdata[15:0]}}.
  - word: `mem_be` = 1111; wdata passes through.
- **Load extraction:**
  - byte lane = `mem_rdata` >> (8 × addr[1:0]).
  - half lane = `mem_rdata` >> (16 × addr[1]).
  - Sign-extend unless `ls_unsigned` = 1. Word passes through.
- **RESP:** pulse `if_rvalid` or `ls_rvalid`. Data is taken combinationally from `mem_rdata` using the captured size, offset and unsigned flag.
- **Idle values:** all `mem_*` strobes are 0, `mem_be` = 0000, and `mem_wdata` = 0 outside ISSUE.

## Timing
- A request sampled at cycle T in IDLE gives: grant and memory strobe at T+1 (ISSUE), response at T+2 (RESP).
- The back-to-back rate is one access per 2 cycles: a request seen in RESP at T+2 issues at T+3.
- Grant and response pulses are exactly one cycle wide. A requester may drop `req` or change its inputs in the cycle after its grant.
- Only one of `if_gnt`/`ls_gnt` is asserted per cycle, and likewise only one of `if_rvalid`/`ls_rvalid`.
- When both requesters are held continuously with MAX_LS_STREAK = 4, the grant sequence is L,L,L,L,F,L,L,L,L,F,…
- **Reset:** `rst_n` low forces IDLE asynchronously.
  - All outputs become 0 and `ls_streak` = 0.
  - An in-flight access produces no response and no further memory strobe.
  - The first arbitration happens in the first IDLE cycle after `rst_n` rises.
- A request dropped before its grant is a protocol violation; behaviour is undefined.

## Test plan
- **Lone fetch:** `if_addr` = 0x804, `mem_rdata` = 0x00A00093. Expect `if_gnt` at T+1 with `mem_addr` = 0x201 and `mem_ld` = 1; `if_rvalid` at T+2 with `if_rdata` = 0x00A00093.
- **SB:** `ls_addr` = 0x106, `ls_wdata` = 0xDEADBEEF. Expect `mem_be` = 0100, `mem_wdata` = 0xEFEFEFEF, `mem_addr` = 0x041, then `ls_rvalid` = 1 with `ls_err` = 0.
- **Sign-extended loads:** LH at `ls_addr` 0x0FE with `mem_rdata` = 0x8001_1234 gives `ls_rdata` = 0xFFFF8001. LBU at 0x0FD gives 0x00000012.
- **Misaligned:** LW at 0x103. Expect `ls_gnt` with no `mem_ld`, then `ls_rvalid` = 1, `ls_err` = 1, `ls_rdata` = 0.
- **Contention:** hold `if_req` and `ls_req` for 20 cycles. Expect the grant order L,L,L,L,F repeated, never two grants in one cycle, and fetch grants spaced 10 cycles apart.
- **Reset mid-access:** pull `rst_n` low during ISSUE of a load. Expect all outputs 0 immediately and no `ls_rvalid`; after release, a pending `if_req` is granted 1 cycle later.
